fifo_rptr_ctrl: RTL and testbench

//  Read-side pointer/flag controller of the JTAG async FIFO (rclk domain); pairs with the write-side pointer block.

---
 rtl/fifo_rptr_ctrl_pkg.sv | 25 ++
 rtl/fifo_rptr_ctrl_ptr_sync.sv | 30 +++
 rtl/fifo_rptr_ctrl.sv | 74 +++++++
 tb/tb_fifo_rptr_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rptr_ctrl_pkg.sv
// Shared pointer types and Gray/binary helpers for the async FIFO pointer blocks.
// The helpers work on a wide vector so callers of any width up to PTR_MAX_W can zero-extend and truncate.
package fifo_rptr_ctrl_pkg;

  localparam int PTR_MAX_W      = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
  typedef logic [PTR_MAX_W-1:0]      ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs keep upper bits at 0, so the prefix XOR from the MSB stays exact.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
    ptr_wide_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rptr_ctrl_ptr_sync.sv
// Multi-bit flop synchronizer for Gray pointers crossing clock domains.
// Only safe for values that change one bit at a time between source clock steps.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_rptr_ctrl.sv
// Read-side pointer and flag controller of the async FIFO, running in the rclk domain.
// Flags are computed from next-state pointers so they update on the same edge as the pop.
module fifo_rptr_ctrl
  import fifo_rptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH-1:0] wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] rptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] rcount,
  output logic                  underflow
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t AE_LIMIT = ADDR_WIDTH'(AE_THRESH);

  addr_t sync_wptr;
  addr_t sync_waddr;
  addr_t nxt_raddr;
  addr_t nxt_rptr;
  addr_t nxt_count;
  logic  do_pop;

  ptr_sync #(
    .WIDTH  (ADDR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (rclk),
    .rst (r_rst),
    .d   (wptr),
    .q   (sync_wptr)
  );

  assign sync_waddr = ADDR_WIDTH'(gray2bin(PTR_MAX_W'(sync_wptr)));

  // Modular subtraction keeps the occupancy right across the address wrap.
  always_comb begin
    do_pop    = rinc && !empty;
    nxt_raddr = raddr;
    if (do_pop) begin
      nxt_raddr = raddr + 1'b1;
    end
    nxt_rptr  = ADDR_WIDTH'(bin2gray(PTR_MAX_W'(nxt_raddr)));
    nxt_count = sync_waddr - nxt_raddr;
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      raddr        <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rcount       <= '0;
      underflow    <= 1'b0;
    end else begin
      raddr        <= nxt_raddr;
      rptr         <= nxt_rptr;
      empty        <= (nxt_raddr == sync_waddr);
      almost_empty <= (nxt_count <= AE_LIMIT);
      rcount       <= nxt_count;
      underflow    <= rinc && empty;
    end
  end

endmodule

// File: tb/tb_fifo_rptr_ctrl.sv
// Self-checking bench for fifo_rptr_ctrl: directed scenarios plus randomized traffic.
// Expectations come from a pointer-count model that treats the synchronizer as a pure delay.
module tb_fifo_rptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int SYNC  = 2;
  localparam int AE    = 1;

  logic          rclk;
  logic          r_rst;
  logic          rinc;
  logic [AW-1:0] wptr;
  logic [AW-1:0] raddr;
  logic [AW-1:0] rptr;
  logic          empty;
  logic          almost_empty;
  logic [AW-1:0] rcount;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Model state: pointers as plain integers, sync path as a queue of past write samples.
  int m_rd;
  int m_w;
  int m_count;
  bit m_empty;
  bit m_ae;
  bit m_uf;
  int m_wq[$];

  fifo_rptr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SYNC),
    .AE_THRESH   (AE)
  ) dut (
    .rclk         (rclk),
    .r_rst        (r_rst),
    .rinc         (rinc),
    .wptr         (wptr),
    .raddr        (raddr),
    .rptr         (rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rcount       (rcount),
    .underflow    (underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [AW-1:0] gray_of(input int v);
    int b;
    b = v % DEPTH;
    return AW'(b ^ (b >> 1));
  endfunction

  function automatic logic [14:0] got_vec();
    return {raddr, rptr, empty, almost_empty, rcount, underflow};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {AW'(m_rd), gray_of(m_rd), m_empty, m_ae, AW'(m_count), m_uf};
  endfunction

  task automatic model_reset();
    m_rd    = 0;
    m_count = 0;
    m_empty = 1'b1;
    m_ae    = 1'b1;
    m_uf    = 1'b0;
    m_wq.delete();
    for (int i = 0; i < SYNC; i++) m_wq.push_back(0);
  endtask

  // Drives one cycle between edges, then advances the model across the rising edge.
  task automatic step(input logic r, input int w);
    int ws;
    bit pop;
    @(negedge rclk);
    rinc = r;
    m_w  = w % DEPTH;
    wptr = gray_of(m_w);
    @(posedge rclk);
    ws = m_wq.pop_front();
    m_wq.push_back(m_w);
    pop     = r && !m_empty;
    m_uf    = r && m_empty;
    m_rd    = (m_rd + int'(pop)) % DEPTH;
    m_count = (ws - m_rd + DEPTH) % DEPTH;
    m_empty = (m_count == 0);
    m_ae    = (m_count <= AE);
    #1;
  endtask

  task automatic test_reset();
    r_rst = 1'b1;
    rinc  = 1'b0;
    m_w   = 0;
    wptr  = '0;
    model_reset();
    repeat (3) @(posedge rclk);
    #1;
    checks++;
    if (got_vec() !== 15'b0000_0000_1_1_0000_0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h", got_vec(), 15'b0000_0000_1_1_0000_0);
    end
    @(negedge rclk);
    r_rst = 1'b0;
  endtask

  task automatic test_sync_latency();
    for (int e = 1; e <= SYNC + 1; e++) begin
      step(1'b0, 3);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL sync_latency edge %0d: got %h expected %h", e, got_vec(), exp_vec());
      end
      checks++;
      if (empty !== (e <= SYNC)) begin
        errors++;
        $display("[TB] FAIL sync_empty edge %0d: got %b expected %b", e, empty, (e <= SYNC));
      end
    end
    checks++;
    if ({rcount, almost_empty} !== {4'd3, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sync_rcount: got %0d/%b expected 3/0", rcount, almost_empty);
    end
  endtask

  task automatic test_drain_underflow();
    logic [AW-1:0] exp_rptr [3];
    exp_rptr[0] = 4'b0001;
    exp_rptr[1] = 4'b0011;
    exp_rptr[2] = 4'b0010;
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 3);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL drain pop %0d: got %h expected %h", p + 1, got_vec(), exp_vec());
      end
      if (p < 3) begin
        checks++;
        if (rptr !== exp_rptr[p]) begin
          errors++;
          $display("[TB] FAIL drain_rptr pop %0d: got %b expected %b", p + 1, rptr, exp_rptr[p]);
        end
      end
    end
    checks++;
    if ({raddr, underflow, empty} !== {4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL underflow_hold: got raddr=%0d uf=%b empty=%b expected 3/1/1", raddr, underflow, empty);
    end
    step(1'b0, 3);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow_pulse: got %b expected 0", underflow);
    end
  endtask

  task automatic test_wrap();
    repeat (SYNC + 1) step(1'b0, 2);
    checks++;
    if (rcount !== 4'd15 || got_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL wrap_fill: got %h expected %h", got_vec(), exp_vec());
    end
    for (int p = 0; p < 15; p++) begin
      step(1'b1, 2);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL wrap pop %0d: got %h expected %h", p + 1, got_vec(), exp_vec());
      end
    end
    checks++;
    if ({raddr, empty} !== {4'd2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wrap_end: got raddr=%0d empty=%b expected 2/1", raddr, empty);
    end
  endtask

  task automatic test_simultaneous();
    int w;
    w = (m_rd + 1) % DEPTH;
    repeat (SYNC + 1) step(1'b0, w);
    checks++;
    if (rcount !== 4'd1) begin
      errors++;
      $display("[TB] FAIL simul_setup: got rcount %0d expected 1", rcount);
    end
    w = (w + 1) % DEPTH;
    repeat (SYNC) step(1'b0, w);
    step(1'b1, w);
    checks++;
    if ({rcount, empty} !== {4'd1, 1'b0} || got_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL simultaneous: got %h expected %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_midop_reset();
    int w;
    w = (m_rd + 5) % DEPTH;
    repeat (SYNC + 1) step(1'b0, w);
    checks++;
    if (rcount !== 4'd5) begin
      errors++;
      $display("[TB] FAIL midop_setup: got rcount %0d expected 5", rcount);
    end
    #2;
    r_rst = 1'b1;
    m_w   = 0;
    wptr  = '0;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 15'b0000_0000_1_1_0000_0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got %h expected %h", got_vec(), 15'b0000_0000_1_1_0000_0);
    end
    @(negedge rclk);
    r_rst = 1'b0;
  endtask

  task automatic test_random();
    int w;
    logic r;
    w = m_w;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && ((w + 1 - m_rd + DEPTH) % DEPTH) != 0) begin
        w = (w + 1) % DEPTH;
      end
      r = ($urandom_range(0, 1) == 1);
      step(r, w);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", c, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_drain_underflow();
    test_wrap();
    test_simultaneous();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
